// File: rtl/rsa_word_port.sv
// Word-serial host port for the ModExp core: assembles five operands from
// parallel word lanes and streams the captured result back, LSW first.
module rsa_word_port #(
  parameter int DATA_WIDTH = 64,
  parameter int WIDTH      = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] m_word,
  input  logic [DATA_WIDTH-1:0] e_word,
  input  logic [DATA_WIDTH-1:0] n_word,
  input  logic [DATA_WIDTH-1:0] r_word,
  input  logic [DATA_WIDTH-1:0] t_word,
  output logic [WIDTH-1:0]      m_op,
  output logic [WIDTH-1:0]      e_op,
  output logic [WIDTH-1:0]      n_op,
  output logic [WIDTH-1:0]      r_op,
  output logic [WIDTH-1:0]      t_op,
  output logic                  operands_ready,
  input  logic [WIDTH-1:0]      res_in,
  input  logic                  res_valid,
  output logic                  result_ready,
  input  logic                  get_result,
  output logic [DATA_WIDTH-1:0] res_out,
  output logic                  out_valid,
  output logic                  out_last,
  output logic [2:0]            port_state
);

  localparam int WORDS = WIDTH / DATA_WIDTH;
  localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_READY  = 3'd2,
    S_HOLD   = 3'd3,
    S_UNLOAD = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [IW-1:0]         oidx_q, oidx_d;
  logic [WIDTH-1:0]      m_op_q, m_op_d;
  logic [WIDTH-1:0]      e_op_q, e_op_d;
  logic [WIDTH-1:0]      n_op_q, n_op_d;
  logic [WIDTH-1:0]      r_op_q, r_op_d;
  logic [WIDTH-1:0]      t_op_q, t_op_d;
  logic [WIDTH-1:0]      result_q, result_d;
  logic [DATA_WIDTH-1:0] res_out_q, res_out_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;

  // Handshake: all host-side strobes (load_start, res_valid, get_result) are
  // single-cycle requests honoured only in the state that expects them; in_valid
  // qualifies one word on every lane; out_valid has no backpressure.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    oidx_d      = oidx_q;
    m_op_d      = m_op_q;
    e_op_d      = e_op_q;
    n_op_d      = n_op_q;
    r_op_d      = r_op_q;
    t_op_d      = t_op_q;
    result_d    = result_q;
    res_out_d   = res_out_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          m_op_d[idx_q*DATA_WIDTH +: DATA_WIDTH] = m_word;
          e_op_d[idx_q*DATA_WIDTH +: DATA_WIDTH] = e_word;
          n_op_d[idx_q*DATA_WIDTH +: DATA_WIDTH] = n_word;
          r_op_d[idx_q*DATA_WIDTH +: DATA_WIDTH] = r_word;
          t_op_d[idx_q*DATA_WIDTH +: DATA_WIDTH] = t_word;
          if (idx_q == LAST_IDX) begin
            state_d = S_READY;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_READY: begin
        // A reload wins over a result arriving in the same cycle.
        if (load_start) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end else if (res_valid) begin
          result_d = res_in;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (get_result) begin
          state_d = S_UNLOAD;
          oidx_d  = '0;
        end
      end
      S_UNLOAD: begin
        res_out_d   = result_q[oidx_q*DATA_WIDTH +: DATA_WIDTH];
        out_valid_d = 1'b1;
        if (oidx_q == LAST_IDX) begin
          out_last_d = 1'b1;
          state_d    = S_IDLE;
          oidx_d     = '0;
        end else begin
          oidx_d = oidx_q + IW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      oidx_q      <= '0;
      m_op_q      <= '0;
      e_op_q      <= '0;
      n_op_q      <= '0;
      r_op_q      <= '0;
      t_op_q      <= '0;
      result_q    <= '0;
      res_out_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      oidx_q      <= oidx_d;
      m_op_q      <= m_op_d;
      e_op_q      <= e_op_d;
      n_op_q      <= n_op_d;
      r_op_q      <= r_op_d;
      t_op_q      <= t_op_d;
      result_q    <= result_d;
      res_out_q   <= res_out_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign m_op           = m_op_q;
  assign e_op           = e_op_q;
  assign n_op           = n_op_q;
  assign r_op           = r_op_q;
  assign t_op           = t_op_q;
  assign operands_ready = (state_q == S_READY);
  assign result_ready   = (state_q == S_HOLD);
  assign res_out        = res_out_q;
  assign out_valid      = out_valid_q;
  assign out_last       = out_last_q;
  assign port_state     = state_q;

endmodule

// File: doc/rsa_word_port.md
# rsa_word_port

Core-side end of the 64-bit word-serial host protocol for the 4096-bit modular-exponentiation engine. The block receives five operands (message m, exponent e, modulus n, Montgomery constants r and t) from the host, one word per lane per cycle, least-significant word first, and assembles them into full-width registers for the core. It captures the core's full-width result and streams it back to the host in the same word order. It sits between the host/bus adapter and the ModExp datapath and replaces ad-hoc per-operand slicing in the core.

## Interface
- DATA_WIDTH, 64, word width of every serial lane
- WIDTH, 4096, operand/result width; must be a multiple of DATA_WIDTH
- WORDS, WIDTH/DATA_WIDTH (64), words per operand; derived, not overridden
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- load_start  in  1  single-cycle request to begin an operand load
- in_valid  in  1  m/e/n/r/t_word lanes carry a valid word this cycle
- m_word, e_word, n_word, r_word, t_word  in  DATA_WIDTH each  operand word lanes, same word index on all five lanes
- m_op, e_op, n_op, r_op, t_op  out  WIDTH each  assembled operands to the core
- operands_ready  out  1  level; all WORDS words loaded, operands stable
- res_in  in  WIDTH  core result
- res_valid  in  1  single-cycle strobe; res_in valid
- result_ready  out  1  level; result captured, awaiting get_result
- get_result  in  1  single-cycle request to stream the result out
- res_out  out  DATA_WIDTH  result word, registered
- out_valid  out  1  res_out carries a valid word
- out_last  out  1  coincides with the final (index WORDS-1) word
- port_state  out  3  current FSM state encoding, for debug/status

## Operation
- States: IDLE=0, LOAD=1, READY=2, HOLD=3, UNLOAD=4. Other encodings go to IDLE on the next edge.
- IDLE: load_start → LOAD, idx←0. in_valid, res_valid and get_result are ignored.
- LOAD: when in_valid is high, each lane word is written to op[idx*DATA_WIDTH +: DATA_WIDTH] and idx increments. When in_valid is high with idx==WORDS-1 → READY. Cycles with in_valid low hold the state; there is no timeout. load_start in LOAD is ignored.
- READY: operands_ready=1, and operand registers stay constant. res_valid → capture res_in into the result register → HOLD. load_start → LOAD with idx←0 (reload); load_start takes priority over a simultaneous res_valid, and that result is discarded.
- HOLD: result_ready=1. Operands are retained. get_result → UNLOAD, oidx←0. load_start in HOLD is ignored; the result must be drained first.
- UNLOAD: each cycle res_out←result[oidx*DATA_WIDTH +: DATA_WIDTH], out_valid=1, oidx increments. out_last=1 on oidx==WORDS-1, then → IDLE.
- Operand registers are not cleared by a new load. They are overwritten word by word, so a full load always fully replaces them.
- idx/oidx are $clog2(WORDS) bits wide. There is no wrap-around: the state transition occurs on the final index.
- Reset (any state, including mid-LOAD or mid-UNLOAD):
  - state→IDLE; idx, oidx →0
  - all operand and result registers →0
  - operands_ready, result_ready, out_valid, out_last →0; res_out →0
  - partial transfers are abandoned

## Timing
- Load: load_start sampled at edge L gives LOAD after L, so the first word can be sampled at L+1. With continuous in_valid, words are sampled at L+1..L+WORDS and operands_ready is high after edge L+WORDS.
- Result capture: res_valid sampled at edge C gives result_ready high after C.
- Unload: get_result sampled at edge G. out_valid is high for exactly WORDS cycles, after edges G+1..G+WORDS, with word k after edge G+1+k. out_last is high after G+WORDS only. State is IDLE, with out_valid low, after G+WORDS+1.
- out_valid/out_last/res_out are registered. out_valid is low and res_out holds its last value outside UNLOAD.
- operands_ready and result_ready decode directly from state; there is no extra latency.

## Test plan
- Small operands: load m=8, e=13, n=77, r=t=0, words 1..63 zero, continuous in_valid. Required: m_op=8, e_op=13, n_op=77; operands_ready asserted exactly 64 cycles after load_start.
- Loopback result: in READY, res_valid with res_in=50 (8^13 mod 77), then get_result. Required:
  - 64 words; word0=0x32, words 1..63 =0
  - out_last only on word 63
  - IDLE next cycle
- Gapped load: full-width random operands with in_valid deasserted on every third cycle. Required: operands equal the reference vectors, and operands_ready comes only after the 64th valid word.
- Priority: load_start and res_valid in the same READY cycle. Required: state LOAD, result_ready stays 0, and a fresh 64-word load overwrites operands.
- Ignored requests:
  - get_result in IDLE/READY, and res_valid in IDLE/LOAD: no state change
  - load_start in HOLD and in UNLOAD: no state change
- Reset mid-operation: assert reset at word 30 of LOAD, and separately at word 20 of UNLOAD. Required:
  - next cycle IDLE, all outputs and registers 0
  - a subsequent complete load/unload is correct
